// File: rtl/life_pkg.sv
// Shared constants, FSM encoding and cell-rule helpers for the Life generation engine.
package life_pkg;

    localparam int ROWS    = 16;
    localparam int COLS    = 16;
    localparam int BOARD_W = ROWS * COLS;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPUTE = 1'b1
    } state_t;

    localparam logic [3:0] BIRTH   = 4'd3;
    localparam logic [3:0] SURVIVE = 4'd2;

    // Flat bit position of cell (r,c) on the default-sized board.
    function automatic int cell_idx(input int r, input int c);
        return r * COLS + c;
    endfunction

    // Population count of the eight neighbour bits (result 0..8).
    function automatic logic [3:0] count8(input logic [7:0] nb);
        logic [3:0] sum;
        sum = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum = sum + {3'b000, nb[i]};
        end
        return sum;
    endfunction

    // B3/S23: birth on exactly three neighbours, survival on two or three.
    function automatic logic next_cell(input logic alive, input logic [3:0] cnt);
        return (cnt == BIRTH) | (alive & (cnt == SURVIVE));
    endfunction

endpackage

// File: rtl/life_row_eval.sv
// Combinational next-state evaluation of one board row from its two vertical neighbours.
module life_row_eval #(
    parameter int COLS = 16,
    parameter int WRAP = 1
) (
    input  logic [COLS-1:0] i_above,
    input  logic [COLS-1:0] i_centre,
    input  logic [COLS-1:0] i_below,
    output logic [COLS-1:0] o_next
);
    import life_pkg::*;

    // Rows padded by one column each side: bit k+1 is column k, bit 0 is column -1,
    // bit COLS+1 is column COLS. Padding is the wrapped column or a dead cell.
    logic [COLS+1:0] w_ext_a;
    logic [COLS+1:0] w_ext_c;
    logic [COLS+1:0] w_ext_b;

    // Build the padded rows according to the edge policy.
    always_comb begin
        w_ext_a = '0;
        w_ext_c = '0;
        w_ext_b = '0;
        if (WRAP != 0) begin
            w_ext_a = {i_above[0],  i_above,  i_above[COLS-1]};
            w_ext_c = {i_centre[0], i_centre, i_centre[COLS-1]};
            w_ext_b = {i_below[0],  i_below,  i_below[COLS-1]};
        end else begin
            w_ext_a = {1'b0, i_above,  1'b0};
            w_ext_c = {1'b0, i_centre, 1'b0};
            w_ext_b = {1'b0, i_below,  1'b0};
        end
    end

    for (genvar gc = 0; gc < COLS; gc++) begin : g_cell
        logic [7:0] w_nb;
        assign w_nb = {w_ext_a[gc], w_ext_a[gc+1], w_ext_a[gc+2],
                       w_ext_c[gc],                w_ext_c[gc+2],
                       w_ext_b[gc], w_ext_b[gc+1], w_ext_b[gc+2]};
        assign o_next[gc] = next_cell(i_centre[gc], count8(w_nb));
    end

endmodule

// File: rtl/life_generation_engine.sv
// Row-serial Conway B3/S23 engine: snapshots the board on a step request, evaluates one
// row per clock into a work buffer and publishes the full generation on board_next.
module life_generation_engine #(
    parameter int ROWS  = 16,
    parameter int COLS  = 16,
    parameter int WRAP  = 1,
    parameter int GEN_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 step,
    input  logic [ROWS*COLS-1:0] board_in,
    output logic [ROWS*COLS-1:0] board_next,
    output logic                 busy,
    output logic                 done,
    output logic [GEN_W-1:0]     gen_count
);
    import life_pkg::*;

    localparam int              RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int              LBW      = ROWS * COLS;
    localparam logic [RW-1:0]   LAST_ROW = RW'(ROWS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [RW-1:0]      r_row;
    logic [LBW-1:0]     r_snap;
    logic [LBW-1:0]     r_work;
    logic [LBW-1:0]     r_board_next;
    logic [LBW-1:0]     w_merged;
    logic               r_busy;
    logic               r_done;
    logic [GEN_W-1:0]   r_gen;
    logic               w_last;
    logic               w_start;
    logic               w_eval;
    logic               w_finish;
    logic [COLS-1:0]    w_row_a;
    logic [COLS-1:0]    w_row_c;
    logic [COLS-1:0]    w_row_b;
    logic [COLS-1:0]    w_row_n;

    assign w_last = (r_row == LAST_ROW);

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: a step is only taken from IDLE, so requests while busy are dropped.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (step) w_state_nxt = COMPUTE;
                else      w_state_nxt = IDLE;
            end
            COMPUTE: begin
                if (w_last) w_state_nxt = IDLE;
                else        w_state_nxt = COMPUTE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM control strobes for the datapath.
    always_comb begin
        w_start  = 1'b0;
        w_eval   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            IDLE: begin
                w_start = step;
            end
            COMPUTE: begin
                w_eval   = 1'b1;
                w_finish = w_last;
            end
            default: begin
                w_start  = 1'b0;
                w_eval   = 1'b0;
                w_finish = 1'b0;
            end
        endcase
    end

    // Fetch the current row and its vertical neighbours from the frozen snapshot.
    always_comb begin
        w_row_c = r_snap[r_row*COLS +: COLS];
        if (r_row == {RW{1'b0}}) begin
            if (WRAP != 0) w_row_a = r_snap[(ROWS-1)*COLS +: COLS];
            else           w_row_a = '0;
        end else begin
            w_row_a = r_snap[(r_row - 1'b1)*COLS +: COLS];
        end
        if (r_row == LAST_ROW) begin
            if (WRAP != 0) w_row_b = r_snap[0 +: COLS];
            else           w_row_b = '0;
        end else begin
            w_row_b = r_snap[(r_row + 1'b1)*COLS +: COLS];
        end
    end

    life_row_eval #(
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_row_eval (
        .i_above  (w_row_a),
        .i_centre (w_row_c),
        .i_below  (w_row_b),
        .o_next   (w_row_n)
    );

    // Work buffer with the row being evaluated this cycle merged in.
    always_comb begin
        w_merged = r_work;
        w_merged[r_row*COLS +: COLS] = w_row_n;
    end

    // Datapath registers: snapshot, row counter, work buffer, result and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap       <= '0;
            r_row        <= '0;
            r_work       <= '0;
            r_board_next <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_gen        <= '0;
        end else begin
            r_done <= w_finish;
            if (w_start) begin
                r_snap <= board_in;
                r_row  <= '0;
                r_busy <= 1'b1;
            end else if (w_eval) begin
                r_work <= w_merged;
                if (w_finish) begin
                    r_row        <= '0;
                    r_board_next <= w_merged;
                    r_busy       <= 1'b0;
                    r_gen        <= r_gen + {{(GEN_W-1){1'b0}}, 1'b1};
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_row <= r_row;
            end
        end
    end

    assign board_next = r_board_next;
    assign busy       = r_busy;
    assign done       = r_done;
    assign gen_count  = r_gen;

endmodule

// File: tb/tb_life_generation_engine.sv
// Directed self-checking bench for life_generation_engine: a wrapping 16-bit-count
// instance and a non-wrapping 4-bit-count instance share every input.
module tb_life_generation_engine;
    import life_pkg::*;

    logic         clk;
    logic         reset_n;
    logic         step;
    logic [255:0] board_in;
    logic [255:0] board_a;
    logic         busy_a;
    logic         done_a;
    logic [15:0]  gen_a;
    logic [255:0] board_b;
    logic         busy_b;
    logic         done_b;
    logic [3:0]   gen_b;

    int total = 0;
    int bad   = 0;

    logic [255:0] blink_h, blink_v, block4, wrap_h, wrap_v, empty;

    life_generation_engine #(.ROWS(16), .COLS(16), .WRAP(1), .GEN_W(16)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .step(step), .board_in(board_in),
        .board_next(board_a), .busy(busy_a), .done(done_a), .gen_count(gen_a)
    );

    life_generation_engine #(.ROWS(16), .COLS(16), .WRAP(0), .GEN_W(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .step(step), .board_in(board_in),
        .board_next(board_b), .busy(busy_b), .done(done_b), .gen_count(gen_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One generation on both instances; checks latency and the wrapping instance's result.
    task automatic run_gen(input logic [255:0] b, input logic [255:0] exp, input string tag);
        board_in = b;
        step     = 1'b1;
        @(negedge clk);
        step = 1'b0;
        chk({tag, "_busy"}, {255'd0, busy_a}, 256'd1);
        repeat (15) @(negedge clk);
        chk({tag, "_early_done"}, {255'd0, done_a}, 256'd0);
        @(negedge clk);
        chk({tag, "_done"}, {255'd0, done_a}, 256'd1);
        chk({tag, "_idle"}, {255'd0, busy_a}, 256'd0);
        chk({tag, "_board"}, board_a, exp);
    endtask

    initial begin
        int done_cnt;
        int wide;
        int waited;
        logic prev_done;
        logic [255:0] first_res;
        logic [255:0] second_res;

        blink_h = '0; blink_v = '0; block4 = '0; wrap_h = '0; wrap_v = '0; empty = '0;
        blink_h[cell_idx(5, 4)] = 1'b1; blink_h[cell_idx(5, 5)] = 1'b1; blink_h[cell_idx(5, 6)] = 1'b1;
        blink_v[cell_idx(4, 5)] = 1'b1; blink_v[cell_idx(5, 5)] = 1'b1; blink_v[cell_idx(6, 5)] = 1'b1;
        block4[cell_idx(0, 0)] = 1'b1; block4[cell_idx(0, 1)] = 1'b1;
        block4[cell_idx(1, 0)] = 1'b1; block4[cell_idx(1, 1)] = 1'b1;
        wrap_h[cell_idx(0, 15)] = 1'b1; wrap_h[cell_idx(0, 0)] = 1'b1; wrap_h[cell_idx(0, 1)] = 1'b1;
        wrap_v[cell_idx(15, 0)] = 1'b1; wrap_v[cell_idx(0, 0)] = 1'b1; wrap_v[cell_idx(1, 0)] = 1'b1;

        // Reset state
        reset_n  = 1'b0;
        step     = 1'b0;
        board_in = blink_h;
        #1;
        chk("rst_busy",  {255'd0, busy_a}, 256'd0);
        chk("rst_done",  {255'd0, done_a}, 256'd0);
        chk("rst_board", board_a, 256'd0);
        chk("rst_gen",   {240'd0, gen_a}, 256'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_no_step", {255'd0, busy_a}, 256'd0);

        // 1 Blinker oscillates
        run_gen(blink_h, blink_v, "blink1");
        @(negedge clk);
        chk("done_one_cycle", {255'd0, done_a}, 256'd0);
        run_gen(blink_v, blink_h, "blink2");
        chk("blink_gen", {240'd0, gen_a}, 256'd2);

        // 2 Still life and empty board
        run_gen(block4, block4, "block");
        run_gen(empty, empty, "empty");
        chk("gen4", {240'd0, gen_a}, 256'd4);

        // 3 Edge wrap versus dead border
        run_gen(wrap_h, wrap_v, "wrap1");
        chk("wrap0_board", board_b, 256'd0);

        // 4 Step held high; board_in changed mid-generation
        @(negedge clk);
        board_in  = blink_h;
        step      = 1'b1;
        done_cnt  = 0;
        wide      = 0;
        prev_done = 1'b0;
        first_res = '0;
        second_res = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 5) board_in = block4;
            if (done_a) begin
                done_cnt++;
                if (done_cnt == 1) first_res = board_a;
                if (done_cnt == 2) second_res = board_a;
            end
            if (done_a && prev_done) wide++;
            prev_done = done_a;
            if (i == 18) chk("accept_in_done", {255'd0, busy_a}, 256'd1);
        end
        step = 1'b0;
        chk("held_done_count", done_cnt, 256'd2);
        chk("held_done_width", wide, 256'd0);
        chk("snapshot_frozen", first_res, blink_v);
        chk("second_gen",      second_res, block4);
        waited = 0;
        while (busy_a && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_timeout", {255'd0, busy_a}, 256'd0);
        chk("gen8", {240'd0, gen_a}, 256'd8);

        // 5 Reset in the middle of a generation
        @(negedge clk);
        board_in = blink_h;
        step     = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy",  {255'd0, busy_a}, 256'd0);
        chk("mid_rst_done",  {255'd0, done_a}, 256'd0);
        chk("mid_rst_board", board_a, 256'd0);
        chk("mid_rst_gen",   {240'd0, gen_a}, 256'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_gen(blink_h, blink_v, "post_rst");
        chk("post_rst_gen", {240'd0, gen_a}, 256'd1);

        // 6 Four-bit generation counter wraps
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 15; k++) run_gen(empty, empty, "cnt");
        chk("gen_b_15", {252'd0, gen_b}, 256'd15);
        run_gen(empty, empty, "cnt16");
        chk("gen_b_wrap", {252'd0, gen_b}, 256'd0);
        chk("gen_a_16",   {240'd0, gen_a}, 256'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
